// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, exception
// codes, the NOP filler word, fetch FSM states and the delivered bundle type.
package fetch_pkg;

  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;
  localparam int EX_WIDTH   = 3;

  localparam logic [EX_WIDTH:0] EX_NONE               = 4'd0;
  localparam logic [EX_WIDTH:0] EX_INSTR_MISALIGNED   = 4'd1;
  localparam logic [EX_WIDTH:0] EX_INSTR_ACCESS_FAULT = 4'd2;

  localparam logic [INSTR_SIZE:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_SIZE:0]  pc;
    logic [INSTR_SIZE:0] instr;
    logic [EX_WIDTH:0]   excep;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a bundle delivered while decode is stalled.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          unload,
  input  logic          clear,
  input  fetch_bundle_t d,
  output fetch_bundle_t q,
  output logic          full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time and
// hands {PC, instruction, exception} bundles to decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_SIZE:0] RESET_PC       = 32'h0000_0000,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_SIZE:0]  imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INSTR_SIZE:0] imem_resp_data,
  input  logic                imem_resp_error,
  output logic [ADDR_SIZE:0]  PC_out,
  output logic [INSTR_SIZE:0] instr_out,
  output logic [EX_WIDTH:0]   excep_out,
  output logic                pipeline_out_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [ADDR_SIZE:0]  redirect_pc
);

  fetch_state_t        state, state_n;
  logic [ADDR_SIZE:0]  pc, pc_n;
  logic                drop, drop_n;
  logic                mis_pend, mis_pend_n;
  logic [7:0]          count, count_n;
  logic                deliver;
  fetch_bundle_t       deliv_bundle;
  fetch_bundle_t       buf_q;
  logic                buf_full;
  logic                handshake, in_flight, can_req, timeout, misaligned;

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;
  // A request is still owed a response while waiting or while a stale one is pending.
  assign in_flight      = (state == FS_WAIT) || drop;
  assign can_req        = !buf_full && !stall;
  assign timeout        = (state == FS_WAIT) && (count == 8'(TIMEOUT_CYCLES - 1));
  assign misaligned     = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      mis_pend <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      drop     <= drop_n;
      mis_pend <= mis_pend_n;
      count    <= count_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drop_n       = drop;
    mis_pend_n   = mis_pend;
    count_n      = count;
    deliver      = 1'b0;
    deliv_bundle = '{pc: pc, instr: NOP_INSTR, excep: EX_NONE};
    if (flush) begin
      pc_n       = redirect_pc;
      count_n    = '0;
      mis_pend_n = 1'b0;
      if (misaligned) begin
        state_n    = FS_HALT;
        mis_pend_n = 1'b1;
        drop_n     = (in_flight && !imem_resp_valid) || handshake;
      end else if (in_flight && imem_resp_valid) begin
        state_n = FS_REQ;
        drop_n  = 1'b0;
      end else if (in_flight || handshake) begin
        state_n = FS_WAIT;
        drop_n  = 1'b1;
      end else begin
        state_n = FS_REQ;
        drop_n  = 1'b0;
      end
    end else begin
      if (drop && imem_resp_valid && state != FS_WAIT) drop_n = 1'b0;
      case (state)
        FS_IDLE: if (can_req) state_n = FS_REQ;
        FS_REQ: begin
          if (handshake) begin
            state_n = FS_WAIT;
            count_n = '0;
          end
        end
        FS_WAIT: begin
          count_n = count + 8'd1;
          if (imem_resp_valid && drop) begin
            drop_n  = 1'b0;
            state_n = can_req ? FS_REQ : FS_IDLE;
          end else if ((imem_resp_valid && imem_resp_error) || (!imem_resp_valid && timeout)) begin
            deliver            = 1'b1;
            deliv_bundle.excep = EX_INSTR_ACCESS_FAULT;
            state_n            = FS_HALT;
          end else if (imem_resp_valid) begin
            deliver            = 1'b1;
            deliv_bundle.instr = imem_resp_data;
            pc_n               = pc + 32'd4;
            state_n            = can_req ? FS_REQ : FS_IDLE;
          end
        end
        FS_HALT: begin
          if (mis_pend) begin
            deliver            = 1'b1;
            deliv_bundle.excep = EX_INSTR_MISALIGNED;
            mis_pend_n         = 1'b0;
          end
        end
        default: state_n = FS_IDLE;
      endcase
    end
  end

  // Deliveries made while decode is stalled park in the buffer until stall drops.
  fetch_buffer u_buffer (
    .clk    (clk),
    .reset  (reset),
    .load   (deliver && stall),
    .unload (!stall && buf_full && !flush),
    .clear  (flush),
    .d      (deliv_bundle),
    .q      (buf_q),
    .full   (buf_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pipeline_out_valid <= 1'b0;
      PC_out             <= '0;
      instr_out          <= NOP_INSTR;
      excep_out          <= EX_NONE;
    end else if (flush) begin
      pipeline_out_valid <= 1'b0;
    end else if (!stall) begin
      if (buf_full) begin
        {PC_out, instr_out, excep_out} <= buf_q;
        pipeline_out_valid             <= 1'b1;
      end else if (deliver) begin
        {PC_out, instr_out, excep_out} <= deliv_bundle;
        pipeline_out_valid             <= 1'b1;
      end else begin
        pipeline_out_valid <= 1'b0;
      end
    end
  end

endmodule
